// File: rtl/sys_ctrl_tx_mb.sv
// sys_ctrl_tx_mb: transmit-side response controller (REF_CLK domain).
// Serialises multi-byte ALU results or single register-file read bytes
// towards the UART TX data synchroniser. A response that arrives while a
// frame is in flight is parked in a one-entry pending buffer.
// Optional build macro: SYS_CTRL_TX_HDR_EN prefixes every frame with a
// header byte (HDR_ALU for ALU frames, HDR_MEM for memory frames).
module sys_ctrl_tx_mb #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ALU_BYTES  = 2,
  parameter int                    ALU_WIDTH  = DATA_WIDTH * ALU_BYTES,
  parameter bit                    MSB_FIRST  = 1'b0,
  parameter logic [DATA_WIDTH-1:0] HDR_ALU    = 8'hA5,
  parameter logic [DATA_WIDTH-1:0] HDR_MEM    = 8'h5A
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ALU_WIDTH-1:0]  ALU_OUT,
  input  logic                  OUT_Valid,
  input  logic [DATA_WIDTH-1:0] RdDATA,
  input  logic                  RdDATA_VLD,
  input  logic                  Busy,
  input  logic                  enable_pulse,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CTRL_IDLE,
  output logic                  OVF
);

  // Counter must hold ALU_BYTES plus an optional header byte.
  localparam int CW = $clog2(ALU_BYTES + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]            r_state;
  logic [ALU_WIDTH-1:0]  r_shift;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_vld;
  logic                  r_ctrl_idle;
  logic                  r_ovf;
  logic                  r_pend_vld;
  logic                  r_pend_alu;
  logic [ALU_WIDTH-1:0]  r_pend_data;

  logic [1:0]            w_state_next;
  logic                  w_load_vld;
  logic                  w_load_alu;
  logic [ALU_WIDTH-1:0]  w_load_data;
  logic [ALU_WIDTH-1:0]  w_load_rev;
  logic [ALU_WIDTH-1:0]  w_load_ord;
  logic                  w_take_pend;
  logic                  w_store;
  logic                  w_store_alu;
  logic [ALU_WIDTH-1:0]  w_store_data;
  logic                  w_drop;
  logic                  w_alu_left;
  logic                  w_mem_left;
  logic                  w_pend_next;

  // Byte-reversed copy of the load word so the shift register always
  // emits its least-significant byte next, whatever the byte order.
  for (genvar gi = 0; gi < ALU_BYTES; gi++) begin : g_rev
    assign w_load_rev[gi*DATA_WIDTH +: DATA_WIDTH] =
      w_load_data[(ALU_BYTES-1-gi)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Memory frames are a single byte, so only ALU frames are reordered.
  assign w_load_ord = (MSB_FIRST && w_load_alu) ? w_load_rev : w_load_data;

`ifndef SYS_CTRL_TX_HDR_EN
  // Header bytes only exist in the header build.
  logic w_unused_hdr;
  assign w_unused_hdr = ^{HDR_ALU, HDR_MEM};
`endif

  // Load selection (ALU > read byte > pending) and pending-buffer arbitration
  // for strobes that cannot be loaded straight away.
  always_comb begin
    w_load_vld   = 1'b0;
    w_load_alu   = 1'b0;
    w_load_data  = '0;
    w_take_pend  = 1'b0;
    w_store      = 1'b0;
    w_store_alu  = 1'b0;
    w_store_data = '0;
    w_drop       = 1'b0;
    w_alu_left   = OUT_Valid;
    w_mem_left   = RdDATA_VLD;
    if (r_state == S_IDLE) begin
      if (OUT_Valid) begin
        w_load_vld  = 1'b1;
        w_load_alu  = 1'b1;
        w_load_data = ALU_OUT;
        w_alu_left  = 1'b0;
      end else if (RdDATA_VLD) begin
        w_load_vld  = 1'b1;
        w_load_data = ALU_WIDTH'(RdDATA);
        w_mem_left  = 1'b0;
      end else if (r_pend_vld) begin
        w_load_vld  = 1'b1;
        w_load_alu  = r_pend_alu;
        w_load_data = r_pend_data;
        w_take_pend = 1'b1;
      end
    end
    // Leftovers never coincide with a pending load, so the buffer is free
    // exactly when r_pend_vld is low.
    if (w_alu_left) begin
      if (!r_pend_vld) begin
        w_store      = 1'b1;
        w_store_alu  = 1'b1;
        w_store_data = ALU_OUT;
      end else begin
        w_drop = 1'b1;
      end
      if (w_mem_left) w_drop = 1'b1;
    end else if (w_mem_left) begin
      if (!r_pend_vld) begin
        w_store      = 1'b1;
        w_store_data = ALU_WIDTH'(RdDATA);
      end else begin
        w_drop = 1'b1;
      end
    end
    w_pend_next = w_store ? 1'b1 : (w_take_pend ? 1'b0 : r_pend_vld);
  end

  // Next-state decode; GAP always lasts at least one cycle because the
  // transition out of it is only evaluated once GAP has been entered.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_load_vld) w_state_next = S_SEND;
      S_SEND:  if (enable_pulse) w_state_next = S_GAP;
      S_GAP:   if (!Busy) w_state_next = (r_cnt != '0) ? S_SEND : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Frame datapath: state, byte counter, shift register and TX byte/valid.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_tx_data <= '0;
      r_tx_vld  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_load_vld) begin
            r_tx_vld <= 1'b1;
`ifdef SYS_CTRL_TX_HDR_EN
            r_tx_data <= w_load_alu ? HDR_ALU : HDR_MEM;
            r_shift   <= w_load_ord;
            r_cnt     <= w_load_alu ? CW'(ALU_BYTES + 1) : CW'(2);
`else
            r_tx_data <= w_load_ord[DATA_WIDTH-1:0];
            r_shift   <= w_load_ord >> DATA_WIDTH;
            r_cnt     <= w_load_alu ? CW'(ALU_BYTES) : CW'(1);
`endif
          end
        end
        S_SEND: begin
          if (enable_pulse) begin
            r_tx_vld <= 1'b0;
            r_cnt    <= r_cnt - CW'(1);
          end
        end
        S_GAP: begin
          if (!Busy && (r_cnt != '0)) begin
            r_tx_data <= r_shift[DATA_WIDTH-1:0];
            r_shift   <= r_shift >> DATA_WIDTH;
            r_tx_vld  <= 1'b1;
          end
        end
        default: r_tx_vld <= 1'b0;
      endcase
    end
  end

  // One-entry pending buffer: fills from a leftover strobe, frees on load.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pend_vld  <= 1'b0;
      r_pend_alu  <= 1'b0;
      r_pend_data <= '0;
    end else begin
      r_pend_vld <= w_pend_next;
      if (w_store) begin
        r_pend_alu  <= w_store_alu;
        r_pend_data <= w_store_data;
      end
    end
  end

  // Registered status flags: idle indication and drop pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ctrl_idle <= 1'b1;
      r_ovf       <= 1'b0;
    end else begin
      r_ctrl_idle <= (w_state_next == S_IDLE) && !w_pend_next;
      r_ovf       <= w_drop;
    end
  end

  assign TX_P_DATA = r_tx_data;
  assign TX_D_VLD  = r_tx_vld;
  assign CTRL_IDLE = r_ctrl_idle;
  assign OVF       = r_ovf;

endmodule

// File: tb/tb_sys_ctrl_tx_mb.sv
// tb_sys_ctrl_tx_mb: scoreboard bench for sys_ctrl_tx_mb. Two instances:
// default (2 bytes, LSB first) and 4 bytes MSB first. Expected bytes are
// queued when a strobe is driven and popped when the DUT presents a byte.
module tb_sys_ctrl_tx_mb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy, en, sel;
  logic [15:0] alu_a;
  logic        ov_a, rdv_a;
  logic [7:0]  rd_a;
  logic [31:0] alu_b;
  logic        ov_b, rdv_b;
  logic [7:0]  rd_b;
  logic [7:0]  txd_a, txd_b, txd;
  logic        txv_a, txv_b, txv;
  logic        idle_a, idle_b, idle_s;
  logic        ovf_a, ovf_b;
  logic        en_a, en_b;

  int          n_cmp = 0;
  int          n_err = 0;
  int          ovf_cnt_a = 0;
  int          ovf_cnt_b = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  assign en_a   = en & ~sel;
  assign en_b   = en & sel;
  assign txd    = sel ? txd_b : txd_a;
  assign txv    = sel ? txv_b : txv_a;
  assign idle_s = sel ? idle_b : idle_a;

  sys_ctrl_tx_mb u_dut_a (
    .CLK(clk), .RST(rst_n), .ALU_OUT(alu_a), .OUT_Valid(ov_a),
    .RdDATA(rd_a), .RdDATA_VLD(rdv_a), .Busy(busy), .enable_pulse(en_a),
    .TX_P_DATA(txd_a), .TX_D_VLD(txv_a), .CTRL_IDLE(idle_a), .OVF(ovf_a)
  );

  sys_ctrl_tx_mb #(.ALU_BYTES(4), .MSB_FIRST(1'b1)) u_dut_b (
    .CLK(clk), .RST(rst_n), .ALU_OUT(alu_b), .OUT_Valid(ov_b),
    .RdDATA(rd_b), .RdDATA_VLD(rdv_b), .Busy(busy), .enable_pulse(en_b),
    .TX_P_DATA(txd_b), .TX_D_VLD(txv_b), .CTRL_IDLE(idle_b), .OVF(ovf_b)
  );

  always @(negedge clk) begin
    if (ovf_a === 1'b1) ovf_cnt_a++;
    if (ovf_b === 1'b1) ovf_cnt_b++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", tag, got, $time);
    end
  endtask

  task automatic push_alu_a(input logic [15:0] d);
`ifdef SYS_CTRL_TX_HDR_EN
    exp_q.push_back(8'hA5);
`endif
    exp_q.push_back(d[7:0]);
    exp_q.push_back(d[15:8]);
  endtask

  task automatic push_alu_b(input logic [31:0] d);
`ifdef SYS_CTRL_TX_HDR_EN
    exp_q.push_back(8'hA5);
`endif
    exp_q.push_back(d[31:24]);
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
  endtask

  task automatic push_mem(input logic [7:0] d);
`ifdef SYS_CTRL_TX_HDR_EN
    exp_q.push_back(8'h5A);
`endif
    exp_q.push_back(d);
  endtask

  task automatic strobe_a(input logic do_alu, input logic [15:0] a,
                          input logic do_rd, input logic [7:0] r);
    @(negedge clk);
    ov_a = do_alu; alu_a = a; rdv_a = do_rd; rd_a = r;
    @(negedge clk);
    ov_a = 1'b0; rdv_a = 1'b0;
  endtask

  task automatic strobe_b(input logic [31:0] a);
    @(negedge clk);
    ov_b = 1'b1; alu_b = a;
    @(negedge clk);
    ov_b = 1'b0;
  endtask

  // Wait for a valid byte, acknowledge it 3 cycles later, then hold Busy.
  task automatic serve_byte(input int busy_len);
    int         n;
    logic [7:0] e;
    logic [7:0] d0;
    n = 0;
    while (txv !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    chk("vld_wait", {31'b0, txv}, 32'd1);
    if (txv !== 1'b1) return;
    d0 = txd;
    chk("byte_first", {24'b0, d0}, {24'b0, e});
    repeat (3) @(negedge clk);
    chk("byte_held", {24'b0, txd}, {24'b0, e});
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("gap_vld", {31'b0, txv}, 32'd0);
    busy = (busy_len > 0);
    for (int i = 0; i < busy_len; i++) begin
      @(negedge clk);
      chk("busy_no_send", {31'b0, txv}, 32'd0);
    end
    busy = 1'b0;
  endtask

  task automatic serve_all(input int busy_len);
    while (exp_q.size() != 0) serve_byte(busy_len);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (idle_s !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ctrl_idle", {31'b0, idle_s}, 32'd1);
  endtask

  task automatic quiet(input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (txv === 1'b1) seen = 1'b1;
    end
    chk("no_extra_byte", {31'b0, seen}, 32'd0);
  endtask

  initial begin
    int base;
    int n;
    rst_n = 1'b0; busy = 1'b0; en = 1'b0; sel = 1'b0;
    alu_a = '0; ov_a = 1'b0; rd_a = '0; rdv_a = 1'b0;
    alu_b = '0; ov_b = 1'b0; rd_b = '0; rdv_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vld_a",  {31'b0, txv_a},  32'd0);
    chk("rst_data_a", {24'b0, txd_a},  32'd0);
    chk("rst_idle_a", {31'b0, idle_a}, 32'd1);
    chk("rst_ovf_a",  {31'b0, ovf_a},  32'd0);
    chk("rst_vld_b",  {31'b0, txv_b},  32'd0);
    chk("rst_idle_b", {31'b0, idle_b}, 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ALU 16'h1234, LSB first, latency 1
    push_alu_a(16'h1234);
    strobe_a(1'b1, 16'h1234, 1'b0, 8'h00);
    chk("latency", {31'b0, txv_a}, 32'd1);
    serve_all(0);
    wait_idle();
    chk("ovf_t1", ovf_cnt_a, 32'd0);

    // 4-byte MSB-first frame with Busy held in every GAP
    sel = 1'b1;
    push_alu_b(32'hDEADBEEF);
    strobe_b(32'hDEADBEEF);
    chk("latency_b", {31'b0, txv_b}, 32'd1);
    serve_all(10);
    wait_idle();
    sel = 1'b0;

    // Simultaneous ALU and read strobes in IDLE
    base = ovf_cnt_a;
    push_alu_a(16'hABCD);
    push_mem(8'h77);
    strobe_a(1'b1, 16'hABCD, 1'b1, 8'h77);
    serve_all(0);
    wait_idle();
    chk("ovf_simul", ovf_cnt_a - base, 32'd0);

    // Two reads mid-frame: first parked, second dropped
    base = ovf_cnt_a;
    push_alu_a(16'h0102);
    strobe_a(1'b1, 16'h0102, 1'b0, 8'h00);
    push_mem(8'h55);
    strobe_a(1'b0, 16'h0000, 1'b1, 8'h55);
    strobe_a(1'b0, 16'h0000, 1'b1, 8'h66);
    serve_all(0);
    wait_idle();
    quiet(30);
    chk("ovf_drop", ovf_cnt_a - base, 32'd1);

    // Reset during the second SEND of a frame
    push_alu_a(16'h1234);
    strobe_a(1'b1, 16'h1234, 1'b0, 8'h00);
    serve_byte(0);
    n = 0;
    while (txv_a !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("second_send", {31'b0, txv_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_vld",  {31'b0, txv_a}, 32'd0);
    chk("rst_mid_data", {24'b0, txd_a}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    quiet(5);
    push_mem(8'h99);
    strobe_a(1'b0, 16'h0000, 1'b1, 8'h99);
    serve_all(0);
    wait_idle();

    // Memory frame (header-prefixed in the header build)
    push_mem(8'h3C);
    strobe_a(1'b0, 16'h0000, 1'b1, 8'h3C);
    serve_all(0);
    wait_idle();

    chk("ovf_b_never", ovf_cnt_b, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sys_ctrl_tx_mb.md
Name: sys_ctrl_tx_mb

Overview:
- Multi-byte transmit-side response controller for the system controller, in the fast (REF_CLK) domain.
- Accepts ALU results of ALU_BYTES bytes or single register-file read bytes and serialises them byte-by-byte towards the UART TX data synchroniser.
- Provides a one-entry pending buffer so a response arriving mid-frame is not lost.
- Supports configurable byte order and an optional frame header byte.

Parameters:
- DATA_WIDTH, 8, byte width of TX_P_DATA / RdDATA.
- ALU_BYTES, 2, number of bytes in an ALU result (>=1).
- ALU_WIDTH, DATA_WIDTH*ALU_BYTES, ALU_OUT width (derived; not overridden independently).
- MSB_FIRST, 0, 0 = ALU bytes sent least-significant first; 1 = most-significant first.
- HDR_ALU, 8'hA5, header byte for ALU frames (used only with the optional feature).
- HDR_MEM, 8'h5A, header byte for memory frames (used only with the optional feature).

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- ALU_OUT  in  ALU_WIDTH  ALU result; valid when OUT_Valid=1
- OUT_Valid  in  1  one-cycle ALU result strobe
- RdDATA  in  DATA_WIDTH  register-file read data
- RdDATA_VLD  in  1  one-cycle read-data strobe
- Busy  in  1  UART TX busy, already synchronised to CLK
- enable_pulse  in  1  one-cycle acknowledge from the data synchroniser: current byte taken
- TX_P_DATA  out  DATA_WIDTH  byte presented to the synchroniser
- TX_D_VLD  out  1  TX_P_DATA valid
- CTRL_IDLE  out  1  no frame active and pending buffer empty
- OVF  out  1  one-cycle pulse: a response was dropped

Behaviour:
- Reset: state IDLE, TX_P_DATA=0, TX_D_VLD=0, CTRL_IDLE=1, OVF=0. Byte counter, shift register and pending buffer are cleared. Reset mid-frame abandons the frame without a partial completion.
- All outputs are registered.
- States: IDLE, SEND, GAP.
- IDLE:
  - On OUT_Valid, capture ALU_OUT into the shift register and set byte count = ALU_BYTES.
  - Else on RdDATA_VLD, capture RdDATA and set count = 1.
  - Else, if the pending buffer is full, load from it.
  - Any load moves to SEND on the next edge. TX_D_VLD rises the cycle after the strobe (latency 1).
- SEND:
  - TX_D_VLD=1 and TX_P_DATA holds the current byte, stable until enable_pulse.
  - On enable_pulse, decrement the count and move to GAP.
- GAP:
  - TX_D_VLD=0.
  - Wait for Busy=0. The first GAP cycle is always spent, even if Busy is already 0, so the synchroniser sees a deasserted valid.
  - Then, if count!=0, shift the next byte and go to SEND.
  - Else go to IDLE.
- Byte order:
  - MSB_FIRST=0: bytes ALU_OUT[7:0], [15:8], ...
  - MSB_FIRST=1: reversed order.
  - Memory frames are always one byte.
- Simultaneous OUT_Valid and RdDATA_VLD in IDLE: the ALU result is sent first; the read byte goes to the pending buffer.
- Strobe while not IDLE:
  - Stored in the pending buffer (full ALU_WIDTH plus a type bit) if the buffer is empty.
  - Otherwise dropped and OVF pulses for 1 cycle.
  - Two strobes in the same cycle with the buffer empty: the ALU result is kept, the read byte is dropped, and OVF pulses.
- Pending buffer frees on the cycle its contents load into the shift register.
- Back-to-back frames: IDLE is occupied for exactly 1 cycle between frames.
- enable_pulse outside SEND is ignored.
- Busy is ignored in SEND.
- CTRL_IDLE = (state==IDLE) && pending empty && no strobe this cycle.

Optional Feature:
- Macro SYS_CTRL_TX_HDR_EN.
- Defined: each frame is preceded by a header byte, HDR_ALU for ALU frames and HDR_MEM for memory frames. The header uses the same SEND/GAP handshake, so byte count is ALU_BYTES+1 or 2.
- Undefined: no header; frames contain payload bytes only; HDR_* parameters unused.

Test Plan:
- Defaults, OUT_Valid with ALU_OUT=16'h1234, ack each SEND after 3 cycles, Busy low -> TX_P_DATA 8'h34 then 8'h12, TX_D_VLD first high 1 cycle after strobe, CTRL_IDLE returns to 1, OVF never high.
- ALU_BYTES=4, MSB_FIRST=1, ALU_OUT=32'hDEADBEEF, Busy high 10 cycles in each GAP -> bytes DE, AD, BE, EF; no SEND while Busy=1.
- OUT_Valid (16'hABCD) and RdDATA_VLD (8'h77) in the same IDLE cycle -> CD, AB, then 77; OVF=0.
- During frame 1 (ALU_OUT=16'h0102), RdDATA_VLD 8'h55, then RdDATA_VLD 8'h66 -> 8'h55 sent after frame 1, 8'h66 dropped, exactly one OVF pulse.
- Assert RST during the second SEND of a frame (ALU_OUT=16'h1234) -> TX_D_VLD=0 and TX_P_DATA=0 immediately; after release, new strobe 8'h99 sent cleanly.
- With SYS_CTRL_TX_HDR_EN, RdDATA_VLD 8'h3C -> bytes 5A then 3C.
